hsv_core_issue_dispatch: RTL and testbench
==========================================

HSV_CORE_ISSUE_DISPATCH -- requirements
Module: hsv_core_issue_dispatch

Interface
REQ-001 SHALL have parameter MaxInFlight, default 8, the maximum number of dispatched-but-uncommitted instructions (power of two, 2..32).
REQ-002 SHALL have port clk_core  in  1  the core clock; the block uses one clock only.
REQ-003 SHALL have port rst_core  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush  in  1  discards all pending and in-flight state.
REQ-005 SHALL have ports in_valid  in  1, in_ready  out  1 and in_data  in  issue_data_t, the decoded instruction handshake.
REQ-006 SHALL have ports rs1_addr and rs2_addr  out  reg_addr, and rs1_data and rs2_data  in  word, for register file asynchronous reads.
REQ-007 SHALL have ports alu_valid, branch_valid, ctrl_status_valid and mem_valid  out  1, with matching *_ready  in  1, per execution unit.
REQ-008 SHALL have port out_data  out  exec_mem_data_t, broadcast to all units, and out_common  out  common_data_t.
REQ-009 SHALL have ports commit_valid  in  1, commit_writeback  in  1 and commit_rd_addr  in  reg_addr, the retirement notification.

Function
REQ-010 SHALL drive rs1_addr and rs2_addr combinationally from in_data.common.rs1_addr and in_data.common.rs2_addr.
REQ-011 SHALL keep a busy mask of type reg_mask, with bits 1..31; x0 is never busy.
REQ-012 SHALL assert hazard when rs1_addr, rs2_addr or rd_addr is nonzero and its busy bit is set (RAW plus WAW); hazard uses the registered mask only, with no same-cycle commit bypass.
REQ-013 SHALL define in_ready = !flush & !hazard & (in_flight < MaxInFlight) & (state==EMPTY | the output handshake completes this cycle).
REQ-014 SHALL, on accept (in_valid & in_ready), register in_data and write rs1_data and rs2_data into common.rs1 and common.rs2 of all four exec_mem_data_t substructs; the unit valid rises the next cycle (1-cycle latency).
REQ-015 SHALL, on accept with rd_addr != 0, set busy[rd_addr].
REQ-016 SHALL use a two-state FSM: EMPTY goes to VALID on accept; VALID goes to EMPTY on handshake without a new accept; VALID stays VALID on handshake with a back-to-back accept or while the selected ready is low.
REQ-017 SHALL assert only the *_valid selected by a one-hot exec_select, and only in VALID.
REQ-018 SHALL, when exec_select is not exactly one-hot, route the instruction to ALU with alu_data.illegal forced to 1.
REQ-019 SHALL hold out_data, out_common and *_valid stable while valid is high and ready is low.
REQ-020 SHALL increment in_flight (width $clog2(MaxInFlight)+1) on a unit handshake and decrement it on commit_valid; simultaneous events leave it unchanged; it SHALL never wrap.
REQ-021 SHALL clear busy[commit_rd_addr] on commit_valid & commit_writeback & commit_rd_addr != 0; when a set and a clear hit the same bit in the same cycle, set wins.
REQ-022 SHALL, on flush, next cycle go to EMPTY with all *_valid low, the busy mask zero and in_flight zero; in_ready is 0 in the flush cycle, and a commit in that cycle is ignored.
REQ-023 SHALL ignore commit_valid when in_flight == 0 (no underflow).

Reset
REQ-024 SHALL, on rst_core high at a clk_core edge, set state EMPTY, all *_valid 0, the busy mask 0, in_flight 0 and out_data/out_common to 0.
REQ-025 SHALL give reset priority over flush, accept and commit; reset mid-handshake drops the held instruction.
REQ-026 SHALL hold in_ready at 0 while rst_core is high.

Structure
REQ-027 SHALL place the dispatch_state_t enum (EMPTY, VALID) in hsv_core_pkg under the ISSUE STAGE section.
REQ-028 SHALL place the in-flight count typedef in hsv_core_pkg under ISSUE STAGE, derived from the MaxInFlight constant.
REQ-029 SHALL implement the busy mask, hazard check and set/clear priority in sub-module hsv_core_issue_scoreboard; FSM, counter and routing stay in the top.

Verification
REQ-030 SHALL cover: accept an ALU op with rd=5, alu_ready=1 -> alu_valid=1 next cycle, busy[5]=1, in_flight=1.
REQ-031 SHALL cover: an op reading rs1=5 while busy[5]=1 -> in_ready=0; after commit rd=5 with writeback -> in_ready=1 one cycle later.
REQ-032 SHALL cover: exec_select=4'b1100 -> alu_valid=1 only, with out_data.alu_data.illegal=1.
REQ-033 SHALL cover: mem_ready=0 for 3 cycles -> mem_valid and out_data held constant, in_ready=0, and the op is dispatched on the 4th cycle.
REQ-034 SHALL cover: with MaxInFlight=8, 8 dispatches and no commits -> in_ready=0; a dispatch plus a commit in the same cycle -> in_flight unchanged.
REQ-035 SHALL cover: flush with VALID, busy[3]=1 and in_flight=4 -> next cycle all valids 0, mask 0, in_flight 0, and a simultaneous commit is ignored.

Source files
------------

// File: rtl/hsv_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hsv_core_pkg
// Description : Shared types and constants for the hsv core pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package hsv_core_pkg;

    typedef logic [4:0]  reg_addr;
    typedef logic [31:0] word;
    typedef logic [31:0] reg_mask;

    // Execution-unit select, one bit per unit
    typedef logic [3:0] exec_select_t;
    localparam int unsigned EXEC_ALU         = 3;
    localparam int unsigned EXEC_BRANCH      = 2;
    localparam int unsigned EXEC_CTRL_STATUS = 1;
    localparam int unsigned EXEC_MEM         = 0;
    localparam exec_select_t SEL_ALU         = 4'b1000;
    localparam exec_select_t SEL_BRANCH      = 4'b0100;
    localparam exec_select_t SEL_CTRL_STATUS = 4'b0010;
    localparam exec_select_t SEL_MEM         = 4'b0001;

    typedef struct packed {
        word     pc;
        reg_addr rs1_addr;
        reg_addr rs2_addr;
        reg_addr rd_addr;
        word     rs1;
        word     rs2;
    } common_data_t;

    typedef struct packed {
        common_data_t common;
        logic [3:0]   op;
        logic         illegal;
    } alu_data_t;

    typedef struct packed {
        common_data_t common;
        logic [2:0]   cond;
    } branch_data_t;

    typedef struct packed {
        common_data_t common;
        logic [11:0]  csr_addr;
    } ctrl_status_data_t;

    typedef struct packed {
        common_data_t common;
        logic         store;
        logic [1:0]   size;
    } mem_data_t;

    typedef struct packed {
        alu_data_t         alu_data;
        branch_data_t      branch_data;
        ctrl_status_data_t ctrl_status_data;
        mem_data_t         mem_data;
    } exec_mem_data_t;

    typedef struct packed {
        common_data_t   common;
        exec_select_t   exec_select;
        exec_mem_data_t unit_data;
    } issue_data_t;

    // ======================== ISSUE STAGE ========================
    localparam int unsigned MAX_IN_FLIGHT = 8;

    typedef logic [$clog2(MAX_IN_FLIGHT):0] in_flight_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        VALID = 1'b1
    } dispatch_state_t;

    function automatic logic is_one_hot(input exec_select_t sel);
        return (sel != '0) && ((sel & (sel - 4'd1)) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hsv_core_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hsv_core_issue_scoreboard
// Description : Register busy mask with RAW/WAW hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module hsv_core_issue_scoreboard
    import hsv_core_pkg::*;
(
    input  logic    clk_core,
    input  logic    rst_core,
    input  logic    flush,
    input  reg_addr rs1_addr,
    input  reg_addr rs2_addr,
    input  reg_addr rd_addr,
    input  logic    set_en,
    input  logic    clr_en,
    input  reg_addr clr_addr,
    output logic    hazard
);

    reg_mask r_busy;
    reg_mask w_set;
    reg_mask w_clr;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (set_en && (rd_addr != '0)) begin
            w_set[rd_addr] = 1'b1;
        end
        if (clr_en && (clr_addr != '0)) begin
            w_clr[clr_addr] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle collision leaves the bit busy
    always_ff @(posedge clk_core) begin
        if (rst_core || flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign hazard = ((rs1_addr != '0) && r_busy[rs1_addr]) ||
                    ((rs2_addr != '0) && r_busy[rs2_addr]) ||
                    ((rd_addr  != '0) && r_busy[rd_addr]);

endmodule
`default_nettype wire

// File: rtl/hsv_core_issue_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : hsv_core_issue_dispatch
// Description : Issue stage: hazard-gated accept, operand capture, unit routing.
// Revision    : 1.0 - initial release
// ============================================================================
module hsv_core_issue_dispatch
    import hsv_core_pkg::*;
#(
    parameter int unsigned MaxInFlight = MAX_IN_FLIGHT
) (
    input  logic           clk_core,
    input  logic           rst_core,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  issue_data_t    in_data,
    output reg_addr        rs1_addr,
    output reg_addr        rs2_addr,
    input  word            rs1_data,
    input  word            rs2_data,
    output logic           alu_valid,
    input  logic           alu_ready,
    output logic           branch_valid,
    input  logic           branch_ready,
    output logic           ctrl_status_valid,
    input  logic           ctrl_status_ready,
    output logic           mem_valid,
    input  logic           mem_ready,
    output exec_mem_data_t out_data,
    output common_data_t   out_common,
    input  logic           commit_valid,
    input  logic           commit_writeback,
    input  reg_addr        commit_rd_addr
);

    localparam int unsigned CNT_W = $clog2(MaxInFlight) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MaxInFlight);

    dispatch_state_t  r_state;
    dispatch_state_t  w_state_next;
    logic [CNT_W-1:0] r_in_flight;
    exec_select_t     r_route;
    exec_mem_data_t   r_out_data;
    common_data_t     r_out_common;

    logic           w_hazard;
    logic           w_sel_ready;
    logic           w_handshake;
    logic           w_accept;
    logic           w_commit;
    logic           w_one_hot;
    exec_select_t   w_route;
    common_data_t   w_common;
    exec_mem_data_t w_data;

    assign rs1_addr = in_data.common.rs1_addr;
    assign rs2_addr = in_data.common.rs2_addr;

    // A commit with nothing in flight is spurious and must not touch any state
    assign w_commit = commit_valid && (r_in_flight != '0);

    hsv_core_issue_scoreboard u_scoreboard (
        .clk_core (clk_core),
        .rst_core (rst_core),
        .flush    (flush),
        .rs1_addr (in_data.common.rs1_addr),
        .rs2_addr (in_data.common.rs2_addr),
        .rd_addr  (in_data.common.rd_addr),
        .set_en   (w_accept),
        .clr_en   (w_commit && commit_writeback),
        .clr_addr (commit_rd_addr),
        .hazard   (w_hazard)
    );

    assign w_sel_ready = |(r_route & {alu_ready, branch_ready, ctrl_status_ready, mem_ready});
    assign w_handshake = (r_state == VALID) && w_sel_ready;
    assign in_ready    = !rst_core && !flush && !w_hazard && (r_in_flight < MAX_CNT) &&
                         ((r_state == EMPTY) || w_handshake);
    assign w_accept    = in_valid && in_ready;

    // Operand capture and routing; a malformed select goes to the ALU flagged illegal
    always_comb begin
        w_one_hot     = is_one_hot(in_data.exec_select);
        w_route       = w_one_hot ? in_data.exec_select : SEL_ALU;
        w_common      = in_data.common;
        w_common.rs1  = rs1_data;
        w_common.rs2  = rs2_data;
        w_data        = in_data.unit_data;
        w_data.alu_data.common         = w_common;
        w_data.branch_data.common      = w_common;
        w_data.ctrl_status_data.common = w_common;
        w_data.mem_data.common         = w_common;
        if (!w_one_hot) begin
            w_data.alu_data.illegal = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY:   if (w_accept) w_state_next = VALID;
            VALID:   if (w_handshake && !w_accept) w_state_next = EMPTY;
            default: w_state_next = EMPTY;
        endcase
        if (flush) begin
            w_state_next = EMPTY;
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_state      <= EMPTY;
            r_in_flight  <= '0;
            r_route      <= '0;
            r_out_data   <= '0;
            r_out_common <= '0;
        end else begin
            r_state <= w_state_next;
            if (flush) begin
                r_in_flight <= '0;
            end else if (w_handshake && !w_commit && (r_in_flight != '1)) begin
                r_in_flight <= r_in_flight + 1'b1;
            end else if (w_commit && !w_handshake) begin
                r_in_flight <= r_in_flight - 1'b1;
            end
            if (w_accept) begin
                r_route      <= w_route;
                r_out_data   <= w_data;
                r_out_common <= w_common;
            end
        end
    end

    assign alu_valid         = (r_state == VALID) && r_route[EXEC_ALU];
    assign branch_valid      = (r_state == VALID) && r_route[EXEC_BRANCH];
    assign ctrl_status_valid = (r_state == VALID) && r_route[EXEC_CTRL_STATUS];
    assign mem_valid         = (r_state == VALID) && r_route[EXEC_MEM];
    assign out_data          = r_out_data;
    assign out_common        = r_out_common;

endmodule
`default_nettype wire

// File: tb/tb_hsv_core_issue_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_hsv_core_issue_dispatch
// Description : Directed and randomized bench against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hsv_core_issue_dispatch;
    import hsv_core_pkg::*;

    logic clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    logic           rst_core, flush, in_valid, in_ready;
    issue_data_t    in_data;
    reg_addr        rs1_addr, rs2_addr, commit_rd_addr;
    word            rs1_data, rs2_data;
    logic           alu_valid, alu_ready, branch_valid, branch_ready;
    logic           ctrl_status_valid, ctrl_status_ready, mem_valid, mem_ready;
    exec_mem_data_t out_data;
    common_data_t   out_common;
    logic           commit_valid, commit_writeback;

    hsv_core_issue_dispatch #(.MaxInFlight(8)) dut (
        .clk_core          (clk_core),
        .rst_core          (rst_core),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .rs1_addr          (rs1_addr),
        .rs2_addr          (rs2_addr),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .alu_valid         (alu_valid),
        .alu_ready         (alu_ready),
        .branch_valid      (branch_valid),
        .branch_ready      (branch_ready),
        .ctrl_status_valid (ctrl_status_valid),
        .ctrl_status_ready (ctrl_status_ready),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready),
        .out_data          (out_data),
        .out_common        (out_common),
        .commit_valid      (commit_valid),
        .commit_writeback  (commit_writeback),
        .commit_rd_addr    (commit_rd_addr)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one held instruction slot, a busy bit per register, a count
    bit             m_valid    = 0;
    int             m_route    = 0;
    exec_mem_data_t m_data     = '0;
    common_data_t   m_common   = '0;
    bit [31:0]      m_busy     = '0;
    int             m_inflight = 0;
    exec_mem_data_t exp_hold;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst_core = 0; flush = 0; in_valid = 0;
        commit_valid = 0; commit_writeback = 0; commit_rd_addr = '0;
        alu_ready = 1; branch_ready = 1; ctrl_status_ready = 1; mem_ready = 1;
    endtask

    task automatic set_op(input exec_select_t sel, input reg_addr r1, input reg_addr r2, input reg_addr rd);
        logic [$bits(issue_data_t)-1:0] raw;
        for (int i = 0; i < $bits(issue_data_t); i++) raw[i] = 1'($urandom_range(0, 1));
        in_data = issue_data_t'(raw);
        in_data.exec_select     = sel;
        in_data.common.rs1_addr = r1;
        in_data.common.rs2_addr = r2;
        in_data.common.rd_addr  = rd;
        rs1_data = $urandom();
        rs2_data = $urandom();
    endtask

    // Check the current cycle against the model, advance the model, move to next negedge
    task automatic step();
        bit [3:0]       rdy;
        bit             hs, haz, exp_ready, acc, commit_ok;
        exec_mem_data_t e;
        common_data_t   c;
        #1;
        rdy = {alu_ready, branch_ready, ctrl_status_ready, mem_ready};
        check("alu_valid", alu_valid, m_valid && m_route == EXEC_ALU);
        check("branch_valid", branch_valid, m_valid && m_route == EXEC_BRANCH);
        check("ctrl_status_valid", ctrl_status_valid, m_valid && m_route == EXEC_CTRL_STATUS);
        check("mem_valid", mem_valid, m_valid && m_route == EXEC_MEM);
        check("out_data", out_data, m_data);
        check("out_common", out_common, m_common);
        check("rs1_addr", rs1_addr, in_data.common.rs1_addr);
        check("rs2_addr", rs2_addr, in_data.common.rs2_addr);
        check("in_flight", dut.r_in_flight, m_inflight);
        check("busy_mask", dut.u_scoreboard.r_busy, m_busy);

        hs  = m_valid && rdy[m_route];
        haz = 0;
        if (in_data.common.rs1_addr != 0 && m_busy[in_data.common.rs1_addr]) haz = 1;
        if (in_data.common.rs2_addr != 0 && m_busy[in_data.common.rs2_addr]) haz = 1;
        if (in_data.common.rd_addr  != 0 && m_busy[in_data.common.rd_addr])  haz = 1;
        exp_ready = !rst_core && !flush && !haz && (m_inflight < 8) && (!m_valid || hs);
        check("in_ready", in_ready, exp_ready);
        acc = in_valid && exp_ready;

        if (rst_core) begin
            m_valid = 0; m_route = 0; m_data = '0; m_common = '0; m_busy = '0; m_inflight = 0;
        end else if (flush) begin
            m_valid = 0; m_busy = '0; m_inflight = 0;
        end else begin
            commit_ok  = commit_valid && m_inflight > 0;
            m_inflight = m_inflight + int'(hs) - int'(commit_ok);
            if (commit_ok && commit_writeback && commit_rd_addr != 0) m_busy[commit_rd_addr] = 0;
            if (acc) begin
                if (in_data.common.rd_addr != 0) m_busy[in_data.common.rd_addr] = 1;
                c = in_data.common;
                c.rs1 = rs1_data;
                c.rs2 = rs2_data;
                e = in_data.unit_data;
                e.alu_data.common         = c;
                e.branch_data.common      = c;
                e.ctrl_status_data.common = c;
                e.mem_data.common         = c;
                m_route = EXEC_ALU;
                if ($countones(in_data.exec_select) == 1) begin
                    for (int b = 0; b < 4; b++) if (in_data.exec_select[b]) m_route = b;
                end else begin
                    e.alu_data.illegal = 1;
                end
                m_valid  = 1;
                m_data   = e;
                m_common = c;
            end else if (hs) begin
                m_valid = 0;
            end
        end
        @(negedge clk_core);
    endtask

    task automatic do_reset();
        idle();
        rst_core = 1;
        step();
        rst_core = 0;
    endtask

    function automatic exec_select_t rand_sel();
        if ($urandom_range(0, 4) == 0) return 4'($urandom_range(0, 15));
        return 4'(1 << $urandom_range(0, 3));
    endfunction

    initial begin
        idle();
        set_op(SEL_ALU, 5'd0, 5'd0, 5'd0);
        rst_core = 1;
        in_valid = 1;
        @(negedge clk_core);
        @(negedge clk_core);
        step();
        check("rst_out_data", out_data, '0);

        // Single ALU op writing x5
        idle();
        set_op(SEL_ALU, 5'd0, 5'd0, 5'd5);
        in_valid = 1;
        step();
        in_valid = 0;
        #1 check("d_alu_valid", alu_valid, 1'b1);
        check("d_busy5", dut.u_scoreboard.r_busy[5], 1'b1);
        step();
        check("d_in_flight1", dut.r_in_flight, 4'd1);

        // RAW stall on x5 released by its commit
        set_op(SEL_ALU, 5'd5, 5'd0, 5'd0);
        in_valid = 1;
        commit_valid = 1; commit_writeback = 1; commit_rd_addr = 5'd5;
        #1 check("d_raw_stall", in_ready, 1'b0);
        step();
        commit_valid = 0;
        #1 check("d_raw_release", in_ready, 1'b1);
        step();
        in_valid = 0;
        step();

        // Non-one-hot select routed to ALU as illegal
        set_op(4'b1100, 5'd0, 5'd0, 5'd0);
        in_valid = 1; alu_ready = 0;
        step();
        in_valid = 0;
        #1 check("d_illegal_alu_valid", alu_valid, 1'b1);
        check("d_illegal_branch_valid", branch_valid, 1'b0);
        check("d_illegal_flag", out_data.alu_data.illegal, 1'b1);
        alu_ready = 1;
        step();

        // Memory unit back-pressure for three cycles
        set_op(SEL_MEM, 5'd0, 5'd0, 5'd0);
        in_valid = 1; mem_ready = 0;
        step();
        exp_hold = m_data;
        set_op(SEL_ALU, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            #1 check("d_hold_ready", in_ready, 1'b0);
            check("d_hold_valid", mem_valid, 1'b1);
            check("d_hold_data", out_data, exp_hold);
            step();
        end
        mem_ready = 1;
        #1 check("d_release_ready", in_ready, 1'b1);
        step();
        in_valid = 0;
        check("d_b2b_alu", alu_valid, 1'b1);
        check("d_b2b_mem_low", mem_valid, 1'b0);
        step();

        // In-flight limit, then handshake and commit in the same cycle
        do_reset();
        in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            set_op(SEL_ALU, 5'd0, 5'd0, 5'd0);
            step();
        end
        in_valid = 0;
        step();
        check("d_cap_count", dut.r_in_flight, 4'd8);
        set_op(SEL_ALU, 5'd0, 5'd0, 5'd0);
        in_valid = 1;
        #1 check("d_cap_stall", in_ready, 1'b0);
        in_valid = 0; commit_valid = 1;
        step();
        commit_valid = 0; in_valid = 1; alu_ready = 0;
        step();
        in_valid = 0; alu_ready = 1; commit_valid = 1;
        step();
        commit_valid = 0;
        check("d_hs_commit_same", dut.r_in_flight, 4'd7);

        // Flush with a held op, busy x3 and four in flight; commit ignored
        do_reset();
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            set_op(SEL_ALU, 5'd0, 5'd0, (i == 4) ? 5'd3 : 5'd0);
            step();
        end
        in_valid = 0; alu_ready = 0;
        step();
        check("d_pre_flush_count", dut.r_in_flight, 4'd4);
        check("d_pre_flush_busy3", dut.u_scoreboard.r_busy[3], 1'b1);
        flush = 1; commit_valid = 1; commit_writeback = 1; commit_rd_addr = 5'd3;
        #1 check("d_flush_ready", in_ready, 1'b0);
        step();
        idle();
        check("d_flush_valid", alu_valid, 1'b0);
        check("d_flush_mask", dut.u_scoreboard.r_busy, '0);
        check("d_flush_count", dut.r_in_flight, 4'd0);

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_core = ($urandom_range(0, 299) == 0);
            flush    = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            set_op(rand_sel(), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            alu_ready         = ($urandom_range(0, 9) < 7);
            branch_ready      = ($urandom_range(0, 9) < 7);
            ctrl_status_ready = ($urandom_range(0, 9) < 7);
            mem_ready         = ($urandom_range(0, 9) < 7);
            commit_valid      = ($urandom_range(0, 9) < 4);
            commit_writeback  = ($urandom_range(0, 9) < 7);
            commit_rd_addr    = 5'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
